// File: rtl/port_in_capture.sv
// Memory-mapped 8-bit input port: synchronizer, debounce, sticky edge/change flags, irq.
// Optional macro PORT_IN_FALL_EDGE_EN also latches falling edges of the debounced value.
module port_in_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  PortIn,
  input  logic [2:0]  Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        irq
);

  localparam int unsigned PORT_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_DATA   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_EDGE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_MASK   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(3);

  logic [PORT_W-1:0] sync1;
  logic [PORT_W-1:0] sync2;
  logic [PORT_W-1:0] cand;
  logic [CNT_W-1:0]  cnt;
  logic [PORT_W-1:0] deb;
  logic [PORT_W-1:0] edges;
  logic [PORT_W-1:0] mask;
  logic              changed;

  logic [PORT_W-1:0] deb_nxt;
  logic [PORT_W-1:0] edge_set;
  logic [PORT_W-1:0] edge_clr;
  logic              mask_we;
  logic              status_rd;
  logic              unused_wdata;

  // Candidate is accepted once the counter has seen it stable long enough.
  assign deb_nxt = ((sync2 == cand) && (cnt == CNT_LAST)) ? cand : deb;

`ifdef PORT_IN_FALL_EDGE_EN
  assign edge_set = deb_nxt ^ deb;
`else
  assign edge_set = deb_nxt & ~deb;
`endif

  assign edge_clr     = (MemWrite && (Address == ADDR_EDGE)) ? WriteData[PORT_W-1:0] : '0;
  assign mask_we      = MemWrite && (Address == ADDR_MASK);
  assign status_rd    = MemRead && (Address == ADDR_STATUS);
  assign unused_wdata = ^WriteData[DATA_W-1:PORT_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      cand    <= '0;
      cnt     <= '0;
      deb     <= '0;
      edges   <= '0;
      mask    <= '0;
      changed <= 1'b0;
    end else begin
      sync1 <= PortIn;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + CNT_W'(1);
      end
      deb <= deb_nxt;
      // A new edge wins over a same-cycle W1C on that bit.
      edges <= (edges & ~edge_clr) | edge_set;
      if (mask_we) begin
        mask <= WriteData[PORT_W-1:0];
      end
      // A new change wins over a same-cycle read-clear.
      if (deb_nxt != deb) begin
        changed <= 1'b1;
      end else if (status_rd) begin
        changed <= 1'b0;
      end
    end
  end

  always_comb begin
    ReadData = '0;
    if (MemRead) begin
      case (Address)
        ADDR_DATA:   ReadData = {24'b0, deb};
        ADDR_EDGE:   ReadData = {24'b0, edges};
        ADDR_MASK:   ReadData = {24'b0, mask};
        ADDR_STATUS: ReadData = {16'b0, sync2, 7'b0, changed};
        default:     ReadData = '0;
      endcase
    end
  end

  assign irq = |(edges & mask);

endmodule
